// File: rtl/ov7670_config_sequencer_pkg.sv
// Shared constants and FSM state encoding for the OV7670 register-init sequencer.
package ov7670_pkg;

   localparam logic [15:0] ROM_END   = 16'hFFFF;
   localparam logic [15:0] ROM_DELAY = 16'hFFF0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      SEND,
      WAIT,
      DELAY,
      FINISH
   } state_t;

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// Request/completion channel between the config sequencer and the SCCB write master.
interface ov7670_sccb_if;

   logic       sccb_valid;
   logic       sccb_ready;
   logic [7:0] sccb_reg;
   logic [7:0] sccb_data;
   logic       sccb_done;

   modport master (output sccb_valid, sccb_reg, sccb_data, input sccb_ready, sccb_done);
   modport slave  (input sccb_valid, sccb_reg, sccb_data, output sccb_ready, sccb_done);

endinterface

// File: rtl/ov7670_config_sequencer_delay_timer.sv
// Delay counter: cleared by load, counts while enabled, flags the last cycle of the delay.
module cfg_delay_timer #(
   parameter int DELAY_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic term
);

   localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

   logic [CW-1:0] cnt;

   assign term = (cnt == CW'(DELAY_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (count)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the init ROM from address 0, issuing each {reg, value} pair to the SCCB master;
// FFF0 words insert a fixed delay, FFFF (or the top of the address space) ends the run.
module ov7670_config_sequencer
   import ov7670_pkg::*;
#(
   parameter int DELAY_CYCLES = 250000,
   parameter int ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_dout,
   ov7670_sccb_if.master     sccb,
   output logic              busy,
   output logic              done
);

   state_t state;
   logic   tmr_load, tmr_term, adv;

   assign tmr_load = (state == DECODE) && (rom_dout == ROM_DELAY);
   assign adv      = ((state == WAIT) && sccb.sccb_done) || ((state == DELAY) && tmr_term);

   cfg_delay_timer #(.DELAY_CYCLES(DELAY_CYCLES)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .count (state == DELAY),
      .term  (tmr_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rom_addr        <= '0;
         sccb.sccb_valid <= 1'b0;
         sccb.sccb_reg   <= '0;
         sccb.sccb_data  <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state    <= FETCH;
               rom_addr <= '0;
               busy     <= 1'b1;
               done     <= 1'b0;
            end
            FETCH: state <= DECODE;
            DECODE: begin
               if (rom_dout == ROM_END)
                  state <= FINISH;
               else if (rom_dout == ROM_DELAY)
                  state <= DELAY;
               else begin
                  sccb.sccb_reg   <= rom_dout[15:8];
                  sccb.sccb_data  <= rom_dout[7:0];
                  sccb.sccb_valid <= 1'b1;
                  state           <= SEND;
               end
            end
            SEND: if (sccb.sccb_ready) begin
               sccb.sccb_valid <= 1'b0;
               state           <= WAIT;
            end
            // Last address terminates the run rather than wrapping back to 0.
            WAIT, DELAY: if (adv) begin
               if (rom_addr == '1)
                  state <= FINISH;
               else begin
                  rom_addr <= rom_addr + 1'b1;
                  state    <= FETCH;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench: registered ROM model plus an SCCB slave that completes 5 cycles after accept.
module tb_ov7670_config_sequencer;

   localparam int DC = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_dout;
   logic        busy, done;
   logic        ready = 1'b1;
   logic        stray_done = 1'b0;
   logic        auto_done = 1'b0;
   int          dcnt = 0;
   logic [15:0] rom  [0:255];
   logic [15:0] wlog [0:1023];
   int          wr_cnt = 0;
   int          checks = 0;
   int          failures = 0;
   int          base, k, a1;

   ov7670_sccb_if sif();
   assign sif.sccb_ready = ready;
   assign sif.sccb_done  = auto_done | stray_done;

   ov7670_config_sequencer #(.DELAY_CYCLES(DC), .ADDR_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout),
      .sccb     (sif.master),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_dout <= rom[rom_addr];

   always @(posedge clk) begin
      auto_done <= (dcnt == 1);
      if (dcnt != 0) dcnt <= dcnt - 1;
      if (sif.sccb_valid && sif.sccb_ready) begin
         wlog[wr_cnt % 1024] <= {sif.sccb_reg, sif.sccb_data};
         wr_cnt <= wr_cnt + 1;
         dcnt   <= 5;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
   endtask

   task automatic fill_rom(input logic [15:0] w);
      for (int i = 0; i < 256; i++) rom[i] = w;
   endtask

   initial begin
      fill_rom(16'hFFFF);
      tick(); tick();
      chk("reset", {rom_addr, sif.sccb_valid, sif.sccb_reg, sif.sccb_data, busy, done}, 0);
      rst = 1'b0;
      tick();

      // Basic write
      rom[0] = 16'h1280; rom[1] = 16'h1214; rom[2] = 16'hFFFF;
      base = wr_cnt;
      pulse_start();
      chk("t1_busy", {busy, done}, 2'b10);
      wait_done(200);
      chk("t1_nwr", wr_cnt - base, 2);
      chk("t1_w0", wlog[base % 1024], 16'h1280);
      chk("t1_w1", wlog[(base + 1) % 1024], 16'h1214);
      chk("t1_end", {busy, done}, 2'b01);
      chk("t1_addr", rom_addr, 8'd2);
      tick(); tick(); tick();
      chk("t1_done_hold", {busy, done}, 2'b01);

      // Delay: FETCH+DECODE (2) + DELAY (20) -> addr 1 at 22; FETCH+DECODE again -> valid at 24
      fill_rom(16'hFFFF);
      rom[0] = 16'hFFF0; rom[1] = 16'h1180;
      base = wr_cnt;
      pulse_start();
      k = 0; a1 = -1;
      while (!sif.sccb_valid && k < 100) begin
         tick(); k++;
         if (rom_addr == 8'd1 && a1 < 0) a1 = k;
      end
      chk("t2_addr_adv", a1, 22);
      chk("t2_vld_rise", k, 24);
      chk("t2_payload", {sif.sccb_reg, sif.sccb_data}, 16'h1180);
      wait_done(200);
      chk("t2_nwr", wr_cnt - base, 1);

      // Stray sccb_done in DELAY (k=8) and FETCH (k=22), start mid-run (k=12): timing unchanged
      base = wr_cnt;
      pulse_start();
      k = 0; a1 = -1;
      while (!sif.sccb_valid && k < 100) begin
         tick(); k++;
         if (rom_addr == 8'd1 && a1 < 0) a1 = k;
         stray_done = (k == 8) || (k == 22);
         start      = (k == 12);
      end
      stray_done = 1'b0;
      start      = 1'b0;
      chk("t3_addr_adv", a1, 22);
      chk("t3_vld_rise", k, 24);
      wait_done(200);
      chk("t3_nwr", wr_cnt - base, 1);

      // Backpressure
      fill_rom(16'hFFFF);
      rom[0] = 16'h1234;
      ready = 1'b0;
      base = wr_cnt;
      pulse_start();
      k = 0;
      while (!sif.sccb_valid && k < 20) begin
         tick(); k++;
      end
      chk("t4_vld_lat", k, 2);
      for (int i = 0; i < 7; i++) begin
         chk("t4_hold", {sif.sccb_valid, sif.sccb_reg, sif.sccb_data}, {1'b1, 16'h1234});
         tick();
      end
      chk("t4_no_acc", wr_cnt - base, 0);
      ready = 1'b1;
      tick();
      chk("t4_vld_drop", sif.sccb_valid, 1'b0);
      chk("t4_one_acc", wr_cnt - base, 1);
      wait_done(200);
      chk("t4_no_dup", wr_cnt - base, 1);

      // Reset during WAIT on the 3rd write
      fill_rom(16'hFFFF);
      rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'h0303; rom[3] = 16'h0404;
      base = wr_cnt;
      pulse_start();
      k = 0;
      while (wr_cnt - base < 3 && k < 200) begin
         tick(); k++;
      end
      chk("t5_three", wr_cnt - base, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst", {rom_addr, sif.sccb_valid, sif.sccb_reg, sif.sccb_data, busy, done}, 0);
      for (int i = 0; i < 8; i++) tick();
      base = wr_cnt;
      pulse_start();
      chk("t5_restart", {busy, done}, 2'b10);
      wait_done(300);
      chk("t5_nwr", wr_cnt - base, 4);
      chk("t5_first", wlog[base % 1024], 16'h0101);
      chk("t5_last", wlog[(base + 3) % 1024], 16'h0404);

      // End of address space: no terminator anywhere
      fill_rom(16'h0101);
      base = wr_cnt;
      pulse_start();
      wait_done(6000);
      chk("t6_nwr", wr_cnt - base, 256);
      chk("t6_end", {busy, done}, 2'b01);
      chk("t6_addr", rom_addr, 8'hFF);
      tick(); tick(); tick();
      chk("t6_no_wrap", {rom_addr, busy, done, wr_cnt[15:0] - base[15:0]}, {8'hFF, 2'b01, 16'd256});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
